// File: rtl/ecdsa_sign_sequencer.sv
// Sequences the modular arithmetic unit through s = k^-1 * (z + r*d) mod N and
// reports s together with a fault code for each signing request.
module ecdsa_sign_sequencer #(
    parameter logic [255:0] MODULUS =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [255:0] i_req_z,
    input  logic [255:0] i_req_r,
    input  logic [255:0] i_req_d,
    input  logic [255:0] i_req_k,
    output logic         o_sig_valid,
    input  logic         i_sig_ready,
    output logic [255:0] o_sig_s,
    output logic [2:0]   o_sig_fault,
    output logic [255:0] o_mod_a,
    output logic [255:0] o_mod_b,
    output logic [255:0] o_mod_modulus,
    output logic [2:0]   o_mod_op,
    output logic         o_mod_start,
    input  logic         i_mod_busy,
    input  logic         i_mod_done,
    input  logic [255:0] i_mod_result,
    input  logic         i_mod_error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_INV = 3'b011;

    localparam logic [2:0] F_OK      = 3'd0;
    localparam logic [2:0] F_BAD_K   = 3'd1;
    localparam logic [2:0] F_ARITH   = 3'd2;
    localparam logic [2:0] F_TIMEOUT = 3'd3;
    localparam logic [2:0] F_R_ZERO  = 3'd4;
    localparam logic [2:0] F_S_ZERO  = 3'd5;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    r_state;
    logic [2:0]    r_step;
    logic [TW-1:0] r_timer;
    // r_z is overwritten by z mod N and r_k by k^-1 once those steps complete
    logic [255:0]  r_z;
    logic [255:0]  r_r;
    logic [255:0]  r_d;
    logic [255:0]  r_k;
    logic [255:0]  r_t;
    logic [255:0]  r_mod_a;
    logic [255:0]  r_mod_b;
    logic [2:0]    r_mod_op;
    logic          r_mod_start;
    logic          r_sig_valid;
    logic [255:0]  r_sig_s;
    logic [2:0]    r_sig_fault;

    logic [255:0]  w_op_a;
    logic [255:0]  w_op_b;
    logic [2:0]    w_op_code;
    logic          w_k_bad;
    logic          w_r_bad;

    assign o_req_ready   = (r_state == ST_IDLE);
    assign o_sig_valid   = r_sig_valid;
    assign o_sig_s       = r_sig_s;
    assign o_sig_fault   = r_sig_fault;
    assign o_mod_a       = r_mod_a;
    assign o_mod_b       = r_mod_b;
    assign o_mod_op      = r_mod_op;
    assign o_mod_start   = r_mod_start;
    assign o_mod_modulus = MODULUS;

    assign w_k_bad = (r_k == '0) || (r_k >= MODULUS);
    assign w_r_bad = (r_r == '0) || (r_r >= MODULUS);

    always_comb begin
        w_op_a    = '0;
        w_op_b    = '0;
        w_op_code = OP_ADD;
        case (r_step)
            3'd0: begin
                w_op_a = r_z;
            end
            3'd1: begin
                w_op_a    = r_r;
                w_op_b    = r_d;
                w_op_code = OP_MUL;
            end
            3'd2: begin
                w_op_a = r_z;
                w_op_b = r_t;
            end
            3'd3: begin
                w_op_a    = r_k;
                w_op_code = OP_INV;
            end
            3'd4: begin
                w_op_a    = r_k;
                w_op_b    = r_t;
                w_op_code = OP_MUL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_timer     <= '0;
            r_z         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_k         <= '0;
            r_t         <= '0;
            r_mod_a     <= '0;
            r_mod_b     <= '0;
            r_mod_op    <= OP_ADD;
            r_mod_start <= 1'b0;
            r_sig_valid <= 1'b0;
            r_sig_s     <= '0;
            r_sig_fault <= F_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_z     <= i_req_z;
                        r_r     <= i_req_r;
                        r_d     <= i_req_d;
                        r_k     <= i_req_k;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_k_bad) begin
                        r_sig_fault <= F_BAD_K;
                        r_sig_s     <= '0;
                        r_sig_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_r_bad) begin
                        r_sig_fault <= F_R_ZERO;
                        r_sig_s     <= '0;
                        r_sig_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_step  <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!i_mod_busy) begin
                        r_mod_a     <= w_op_a;
                        r_mod_b     <= w_op_b;
                        r_mod_op    <= w_op_code;
                        r_mod_start <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_mod_start <= 1'b0;
                    if (i_mod_error) begin
                        r_sig_fault <= F_ARITH;
                        r_sig_s     <= '0;
                        r_sig_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (i_mod_done) begin
                        case (r_step)
                            3'd0:    r_z <= i_mod_result;
                            3'd1:    r_t <= i_mod_result;
                            3'd2:    r_t <= i_mod_result;
                            3'd3:    r_k <= i_mod_result;
                            default: ;
                        endcase
                        if (r_step == 3'd4) begin
                            r_sig_valid <= 1'b1;
                            r_state     <= ST_RESP;
                            if (i_mod_result == '0) begin
                                r_sig_fault <= F_S_ZERO;
                                r_sig_s     <= '0;
                            end else begin
                                r_sig_fault <= F_OK;
                                r_sig_s     <= i_mod_result;
                            end
                        end else begin
                            r_step  <= r_step + 3'd1;
                            r_state <= ST_ISSUE;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_sig_fault <= F_TIMEOUT;
                        r_sig_s     <= '0;
                        r_sig_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_sig_ready) begin
                        r_sig_valid <= 1'b0;
                        r_sig_s     <= '0;
                        r_sig_fault <= F_OK;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecdsa_sign_sequencer.sv
// Bench for ecdsa_sign_sequencer: a behavioural arithmetic-unit responder with
// random latency, plus a scoreboard of expected (s, fault) per request.
module tb_ecdsa_sign_sequencer;

    localparam logic [255:0] N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [255:0] req_z, req_r, req_d, req_k;
    logic         sig_valid, sig_ready;
    logic [255:0] sig_s;
    logic [2:0]   sig_fault;
    logic [255:0] mod_a, mod_b, mod_modulus, mod_result;
    logic [2:0]   mod_op;
    logic         mod_start, mod_busy, mod_done, mod_error;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ecdsa_sign_sequencer #(.MODULUS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_z(req_z), .i_req_r(req_r), .i_req_d(req_d), .i_req_k(req_k),
        .o_sig_valid(sig_valid), .i_sig_ready(sig_ready),
        .o_sig_s(sig_s), .o_sig_fault(sig_fault),
        .o_mod_a(mod_a), .o_mod_b(mod_b), .o_mod_modulus(mod_modulus),
        .o_mod_op(mod_op), .o_mod_start(mod_start),
        .i_mod_busy(mod_busy), .i_mod_done(mod_done),
        .i_mod_result(mod_result), .i_mod_error(mod_error)
    );

    int errors = 0;
    int checks = 0;

    logic [255:0] exp_s_q[$];
    logic [2:0]   exp_f_q[$];

    function automatic logic [255:0] addmod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, N};
        return s[255:0];
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        p = p % {256'b0, N};
        return p[255:0];
    endfunction

    // Fermat inverse: a^(N-2) mod N
    function automatic logic [255:0] invmod(input logic [255:0] a);
        logic [255:0] e, r;
        e = N - 256'd2;
        r = 256'd1;
        for (int i = 255; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, a);
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], $urandom()};
        return v;
    endfunction

    // Responder state
    int           lat_fixed = 0;
    int           tail_max = 0;
    int           err_op = -1;
    bit           never_done = 0;
    bit           pend = 0;
    bit           perr = 0;
    bit           rst_seen = 0;
    int           cnt = 0, tail = 0, tail_next = 0;
    int           op_idx = 0, n_starts = 0;
    int           stab_viol = 0, start_busy_viol = 0;
    int unsigned  last_start_cyc = 0;
    logic [255:0] cap_a, cap_b, pres;
    logic [2:0]   cap_op;
    logic [2:0]   op_log[$];

    initial begin
        mod_busy = 1'b0; mod_done = 1'b0; mod_error = 1'b0; mod_result = '0;
        forever begin
            @(posedge clk); #1;
            mod_done = 1'b0; mod_error = 1'b0;
            if (pend && !rst_n) rst_seen = 1;
            if (mod_start === 1'b1 && (pend || tail > 0)) start_busy_viol++;
            if (pend) begin
                if (!rst_seen && (mod_a !== cap_a || mod_b !== cap_b || mod_op !== cap_op))
                    stab_viol++;
                cnt--;
                if (cnt == 0) begin
                    mod_done = 1'b1; mod_result = pres; mod_error = perr;
                    pend = 0; tail = tail_next;
                    if (tail == 0) mod_busy = 1'b0;
                end
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) mod_busy = 1'b0;
            end else if (mod_start === 1'b1) begin
                op_log.push_back(mod_op);
                n_starts++;
                last_start_cyc = cyc;
                cap_a = mod_a; cap_b = mod_b; cap_op = mod_op;
                case (mod_op)
                    3'b000:  pres = addmod(mod_a, mod_b);
                    3'b010:  pres = mulmod(mod_a, mod_b);
                    3'b011:  pres = invmod(mod_a);
                    default: pres = '0;
                endcase
                perr = (op_idx == err_op);
                op_idx++;
                rst_seen = 0;
                if (!never_done) begin
                    mod_busy = 1'b1; pend = 1;
                    cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
                    tail_next = (tail_max > 0) ? int'($urandom_range(0, tail_max)) : 0;
                end
            end
        end
    end

    // Handshake and response capture
    int           hs_wait;
    bit           got_ok, got_stable;
    logic [255:0] got_s;
    logic [2:0]   got_f;
    logic         post_valid, post_ready;
    int unsigned  valid_cyc;

    task automatic send_req(input logic [255:0] z, r, d, k);
        int t;
        op_log.delete(); n_starts = 0; op_idx = 0;
        @(negedge clk);
        req_z = z; req_r = r; req_d = d; req_k = k; req_valid = 1'b1;
        t = 0;
        while (req_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        hs_wait = t;
        if (t >= 200) begin
            errors++;
            $display("FAIL handshake: req_ready never high (waited %0d cycles)", t);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_z = rand256(); req_r = rand256(); req_d = rand256(); req_k = rand256();
    endtask

    task automatic wait_resp(input int hold);
        int t;
        t = 0;
        while (sig_valid !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
        got_ok = (t < 3000);
        valid_cyc = cyc;
        got_s = sig_s; got_f = sig_fault;
        got_stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (sig_valid !== 1'b1 || sig_s !== got_s || sig_fault !== got_f) got_stable = 0;
        end
        sig_ready = 1'b1;
        @(posedge clk); #1;
        sig_ready = 1'b0;
        post_valid = sig_valid; post_ready = req_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({sig_valid, mod_start, sig_fault, mod_op} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b start=%b fault=%0d op=%b want all 0",
                     sig_valid, mod_start, sig_fault, mod_op);
        end
        checks++;
        if (sig_s !== '0 || mod_a !== '0 || mod_b !== '0) begin
            errors++; $display("FAIL reset_data: s=%h a=%h b=%h want 0", sig_s, mod_a, mod_b);
        end
        checks++;
        if (mod_modulus !== N) begin
            errors++; $display("FAIL modulus: got %h want %h", mod_modulus, N);
        end
    endtask

    task automatic test_basic();
        logic [255:0] e_s; logic [2:0] e_f;
        logic [2:0] ops[5];
        ops[0] = 3'b000; ops[1] = 3'b010; ops[2] = 3'b000; ops[3] = 3'b011; ops[4] = 3'b010;
        exp_s_q.push_back(256'd2); exp_f_q.push_back(3'd0);
        send_req(256'd1, 256'd1, 256'd1, 256'd1);
        wait_resp(0);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL basic_s: ok=%b s=%h fault=%0d want s=%h fault=%0d",
                               got_ok, got_s, got_f, e_s, e_f);
        end
        checks++;
        if (n_starts !== 5 || op_log.size() != 5) begin
            errors++; $display("FAIL basic_starts: got %0d want 5", n_starts);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (op_log[i] !== ops[i]) begin
                    errors++; $display("FAIL basic_op%0d: got %b want %b", i, op_log[i], ops[i]);
                end
            end
        end
    endtask

    task automatic test_reduce();
        logic [255:0] e_s; logic [2:0] e_f;
        exp_s_q.push_back(256'd4); exp_f_q.push_back(3'd0);
        send_req(N + 256'd3, 256'd1, 256'd1, 256'd1);
        wait_resp(0);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL reduce: s=%h fault=%0d want s=%h fault=%0d",
                               got_s, got_f, e_s, e_f);
        end
    endtask

    task automatic test_bad_inputs();
        logic [255:0] kv[5], rv[5], e_s; logic [2:0] fv[5], e_f;
        kv[0] = '0;     rv[0] = 256'd1; fv[0] = 3'd1;
        kv[1] = N;      rv[1] = 256'd1; fv[1] = 3'd1;
        kv[2] = 256'd1; rv[2] = '0;     fv[2] = 3'd4;
        kv[3] = 256'd1; rv[3] = N;      fv[3] = 3'd4;
        kv[4] = '0;     rv[4] = '0;     fv[4] = 3'd1;
        for (int i = 0; i < 5; i++) begin
            exp_s_q.push_back('0); exp_f_q.push_back(fv[i]);
            send_req(256'd7, rv[i], 256'd9, kv[i]);
            wait_resp(0);
            e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
            checks++;
            if (!got_ok || got_s !== e_s || got_f !== e_f) begin
                errors++; $display("FAIL bad_in%0d: s=%h fault=%0d want s=0 fault=%0d",
                                   i, got_s, got_f, e_f);
            end
            checks++;
            if (n_starts != 0) begin
                errors++; $display("FAIL bad_in%0d_starts: got %0d want 0", i, n_starts);
            end
        end
    endtask

    task automatic test_s_zero();
        logic [255:0] e_s; logic [2:0] e_f;
        exp_s_q.push_back('0); exp_f_q.push_back(3'd5);
        send_req(N - 256'd1, 256'd1, 256'd1, 256'd1);
        wait_resp(0);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL s_zero: s=%h fault=%0d want s=0 fault=%0d", got_s, got_f, e_f);
        end
    endtask

    task automatic test_error();
        logic [255:0] e_s; logic [2:0] e_f;
        err_op = 3;
        exp_s_q.push_back('0); exp_f_q.push_back(3'd2);
        send_req(256'd3, 256'd4, 256'd5, 256'd6);
        wait_resp(0);
        err_op = -1;
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL arith_err: s=%h fault=%0d want s=0 fault=%0d", got_s, got_f, e_f);
        end
        checks++;
        if (n_starts != 4) begin
            errors++; $display("FAIL arith_err_starts: got %0d want 4", n_starts);
        end
    endtask

    task automatic test_timeout();
        logic [255:0] e_s; logic [2:0] e_f;
        never_done = 1;
        exp_s_q.push_back('0); exp_f_q.push_back(3'd3);
        send_req(256'd1, 256'd1, 256'd1, 256'd1);
        wait_resp(0);
        never_done = 0;
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL timeout: s=%h fault=%0d want s=0 fault=%0d", got_s, got_f, e_f);
        end
        checks++;
        if (n_starts != 1 || valid_cyc - last_start_cyc != TMO) begin
            errors++; $display("FAIL timeout_len: starts=%0d cycles=%0d want 1 and %0d",
                               n_starts, valid_cyc - last_start_cyc, TMO);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] e_s; logic [2:0] e_f;
        exp_s_q.push_back(256'd2); exp_f_q.push_back(3'd0);
        send_req(256'd1, 256'd1, 256'd1, 256'd1);
        wait_resp(10);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f || !got_stable) begin
            errors++; $display("FAIL hold: s=%h fault=%0d stable=%b want s=%h fault=%0d stable=1",
                               got_s, got_f, got_stable, e_s, e_f);
        end
        checks++;
        if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
            errors++; $display("FAIL after_accept: valid=%b ready=%b want 0 1", post_valid, post_ready);
        end
        exp_s_q.push_back(256'd4); exp_f_q.push_back(3'd0);
        send_req(256'd2, 256'd1, 256'd2, 256'd1);
        checks++;
        if (hs_wait != 0) begin
            errors++; $display("FAIL back_to_back: waited %0d cycles want 0", hs_wait);
        end
        wait_resp(0);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL b2b_s: s=%h fault=%0d want s=%h fault=%0d", got_s, got_f, e_s, e_f);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] e_s; logic [2:0] e_f;
        int t; bit stray;
        lat_fixed = 10;
        send_req(256'd1, 256'd1, 256'd1, 256'd1);
        t = 0;
        while (op_idx < 3 && t < 500) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (t >= 500 || {sig_valid, mod_start, sig_fault, mod_op} !== 8'b0 || req_ready !== 1'b1 ||
            mod_a !== '0 || mod_b !== '0 || sig_s !== '0) begin
            errors++; $display("FAIL mid_reset: valid=%b start=%b op=%b ready=%b a=%h want reset values",
                               sig_valid, mod_start, mod_op, req_ready, mod_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        lat_fixed = 0;
        stray = 0; t = 0;
        while ((pend || tail > 0) && t < 100) begin
            @(posedge clk); #1; t++;
            if (mod_start !== 1'b0 || sig_valid !== 1'b0) stray = 1;
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (mod_start !== 1'b0 || sig_valid !== 1'b0) stray = 1;
        end
        checks++;
        if (stray || t >= 100 || n_starts != 3) begin
            errors++; $display("FAIL stray_done: stray=%b starts=%0d want 0 and 3", stray, n_starts);
        end
        exp_s_q.push_back(256'd11); exp_f_q.push_back(3'd0);
        send_req(256'd5, 256'd2, 256'd3, 256'd1);
        wait_resp(0);
        e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
        checks++;
        if (!got_ok || got_s !== e_s || got_f !== e_f) begin
            errors++; $display("FAIL post_reset: s=%h fault=%0d want s=%h fault=%0d",
                               got_s, got_f, e_s, e_f);
        end
    endtask

    task automatic test_random();
        logic [255:0] z, r, d, k, s, e_s; logic [2:0] e_f;
        tail_max = 3;
        for (int i = 0; i < 4; i++) begin
            z = rand256(); r = rand256() % N; d = rand256(); k = rand256() % N;
            if (r == '0) r = 256'd1;
            if (k == '0) k = 256'd1;
            s = mulmod(invmod(k), addmod(addmod(z, '0), mulmod(r, d)));
            exp_s_q.push_back(s); exp_f_q.push_back((s == '0) ? 3'd5 : 3'd0);
            send_req(z, r, d, k);
            wait_resp(int'($urandom_range(0, 3)));
            e_s = exp_s_q.pop_front(); e_f = exp_f_q.pop_front();
            checks++;
            if (!got_ok || got_s !== e_s || got_f !== e_f || n_starts != 5) begin
                errors++; $display("FAIL random%0d: s=%h fault=%0d starts=%0d want s=%h fault=%0d",
                                   i, got_s, got_f, n_starts, e_s, e_f);
            end
        end
        tail_max = 0;
    endtask

    task automatic test_protocol();
        checks++;
        if (stab_viol != 0 || start_busy_viol != 0) begin
            errors++; $display("FAIL protocol: operand changes=%0d starts while busy=%0d want 0 0",
                               stab_viol, start_busy_viol);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; sig_ready = 1'b0;
        req_z = '0; req_r = '0; req_d = '0; req_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_reduce();
        test_bad_inputs();
        test_s_zero();
        test_error();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
